fir_da_serial: RTL and testbench

- Bit-serial distributed-arithmetic (DA) 4-tap FIR filter.
- Operates in the opposite direction to the coefficient-addressed DA filter: each cycle, one bit-plane of the sample history addresses a 16-entry table of precomputed coefficient sums.
- One input bit-plane is processed per clock, LSB first; the MSB plane is subtracted (two's complement).
- Sits on the sample stream with valid/ready input and a one-cycle valid-pulsed, full-precision output.

---
 rtl/fir_da_serial.sv | 186 ++++++++++++++++++
 tb/tb_fir_da_serial.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_da_serial.sv
// fir_da_serial: bit-serial distributed-arithmetic 4-tap FIR filter.
//
// Each accepted sample is pushed into a 4-deep history (x0 newest .. x3 oldest).
// Over the next 8 clocks, one bit-plane of that history per clock (LSB first)
// addresses a 16-entry table of coefficient sums. The looked-up sum is shifted
// by the plane index and added to the accumulator. The MSB plane is subtracted
// (two's complement weight). The result is exact and full precision.
//
// Optional feature macro: FIR_OVF_FLAG_EN
//   When defined, adds output 'ovf'. It flags results outside -1024..1023 and
//   is registered together with filter_out.
//
// Parameters:
//   W0..W3      signed 8-bit coefficients (W0 = newest tap)
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   in_valid    xn is valid
//   in_ready    block can accept a sample (decoded from state only)
//   xn          signed 8-bit input sample
//   out_valid   one-cycle pulse, filter_out holds a new result
//   filter_out  signed 18-bit result
//   ovf         (FIR_OVF_FLAG_EN only) result exceeds 11-bit signed range
module fir_da_serial #(
  parameter logic signed [7:0] W0 = 8'sd1,
  parameter logic signed [7:0] W1 = 8'sd1,
  parameter logic signed [7:0] W2 = 8'sd1,
  parameter logic signed [7:0] W3 = 8'sd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  xn,
  output logic        out_valid,
  output logic [17:0] filter_out
`ifdef FIR_OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // Coefficients sign-extended to the table width. Four 8-bit terms fit in
  // 11 signed bits (|sum| <= 512).
  localparam logic [10:0] C0 = {{3{W0[7]}}, W0};
  localparam logic [10:0] C1 = {{3{W1[7]}}, W1};
  localparam logic [10:0] C2 = {{3{W2[7]}}, W2};
  localparam logic [10:0] C3 = {{3{W3[7]}}, W3};

  state_e      state_q, state_d;
  logic [7:0]  x0_q, x1_q, x2_q, x3_q;
  logic [7:0]  x0_d, x1_d, x2_d, x3_d;
  logic [17:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [17:0] filter_out_q, filter_out_d;

  logic [3:0]  addr;
  logic [10:0] da_term;
  logic [17:0] term_ext;
  logic [17:0] term_shift;
  logic [17:0] acc_sum;

  // Bit-plane k of the history, tap 3 in the MSB of the address.
  assign addr = {x3_q[cnt_q], x2_q[cnt_q], x1_q[cnt_q], x0_q[cnt_q]};

  // Constant coefficient-sum table; folds to a ROM at elaboration.
  always_comb begin
    da_term = '0;
    case (addr)
      4'h0: da_term = '0;
      4'h1: da_term = C0;
      4'h2: da_term = C1;
      4'h3: da_term = C0 + C1;
      4'h4: da_term = C2;
      4'h5: da_term = C0 + C2;
      4'h6: da_term = C1 + C2;
      4'h7: da_term = C0 + C1 + C2;
      4'h8: da_term = C3;
      4'h9: da_term = C0 + C3;
      4'hA: da_term = C1 + C3;
      4'hB: da_term = C0 + C1 + C3;
      4'hC: da_term = C2 + C3;
      4'hD: da_term = C0 + C2 + C3;
      4'hE: da_term = C1 + C2 + C3;
      4'hF: da_term = C0 + C1 + C2 + C3;
      default: da_term = '0;
    endcase
  end

  assign term_ext   = {{7{da_term[10]}}, da_term};
  assign term_shift = term_ext << cnt_q;
  // The MSB plane carries negative weight in two's complement.
  assign acc_sum    = (cnt_q == 3'd7) ? (acc_q - term_shift) : (acc_q + term_shift);

`ifdef FIR_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic ovf_flag;
  // In range -1024..1023 iff bits 17..10 are all copies of the sign bit.
  assign ovf_flag = ~((&acc_sum[17:10]) | ~(|acc_sum[17:10]));
`endif

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    x3_d         = x3_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    filter_out_d = filter_out_q;
`ifdef FIR_OVF_FLAG_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x3_d    = x2_q;
          x2_d    = x1_q;
          x1_d    = x0_q;
          x0_d    = xn;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          filter_out_d = acc_sum;
          out_valid_d  = 1'b1;
          state_d      = StIdle;
`ifdef FIR_OVF_FLAG_EN
          ovf_d        = ovf_flag;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      x0_q         <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      filter_out_q <= '0;
`ifdef FIR_OVF_FLAG_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      filter_out_q <= filter_out_d;
`ifdef FIR_OVF_FLAG_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = out_valid_q;
  assign filter_out = filter_out_q;
`ifdef FIR_OVF_FLAG_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_fir_da_serial.sv
// Testbench for fir_da_serial. Four instances with different coefficient sets
// share one input stream. A negedge monitor predicts in_ready, the exact cycle
// of each out_valid pulse and the exact convolution for every instance.
module tb_fir_da_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  xn = 8'h00;
  logic [3:0]  rdy;
  logic [3:0]  ov;
  logic [3:0][17:0] fo;
  logic [3:0]  ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Coefficients per instance: A=1,2,3,4  B=default  C=all -128  D=mixed.
  localparam int CW [4][4] = '{'{1, 2, 3, 4}, '{1, 1, 1, 1},
                               '{-128, -128, -128, -128}, '{-7, 127, -128, 55}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_da_serial #(.W0(8'sd1), .W1(8'sd2), .W2(8'sd3), .W3(8'sd4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .xn(xn),
    .out_valid(ov[0]), .filter_out(fo[0])
`ifdef FIR_OVF_FLAG_EN
    , .ovf(ovf[0])
`endif
  );
  fir_da_serial u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .xn(xn),
    .out_valid(ov[1]), .filter_out(fo[1])
`ifdef FIR_OVF_FLAG_EN
    , .ovf(ovf[1])
`endif
  );
  fir_da_serial #(.W0(8'h80), .W1(8'h80), .W2(8'h80), .W3(8'h80)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .xn(xn),
    .out_valid(ov[2]), .filter_out(fo[2])
`ifdef FIR_OVF_FLAG_EN
    , .ovf(ovf[2])
`endif
  );
  fir_da_serial #(.W0(8'hF9), .W1(8'h7F), .W2(8'h80), .W3(8'h37)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .xn(xn),
    .out_valid(ov[3]), .filter_out(fo[3])
`ifdef FIR_OVF_FLAG_EN
    , .ovf(ovf[3])
`endif
  );

`ifndef FIR_OVF_FLAG_EN
  assign ovf = 4'h0;
`endif

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit ovf_of(input int y);
    return (y < -1024) || (y > 1023);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int cyc;
    int y0, y1, y2, y3;
  } exp_t;

  exp_t q[$];
  int   hist[4] = '{0, 0, 0, 0};
  int   e0 = -100;

  function automatic int model_y(input int inst);
    int s = 0;
    for (int i = 0; i < 4; i++) s += CW[inst][i] * hist[i];
    return s;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        bit   exp_ready;
        exp_t e;
        exp_ready = !(cyc >= e0 && cyc <= e0 + 7);
        chk("in_ready", int'(rdy), exp_ready ? 15 : 0);
        if (q.size() > 0 && q[0].cyc == cyc) begin
          chk("out_valid_pulse", int'(ov), 15);
          chk("y_a", int'($signed(fo[0])), q[0].y0);
          chk("y_b", int'($signed(fo[1])), q[0].y1);
          chk("y_c", int'($signed(fo[2])), q[0].y2);
          chk("y_d", int'($signed(fo[3])), q[0].y3);
`ifdef FIR_OVF_FLAG_EN
          chk("ovf", int'(ovf), int'({ovf_of(q[0].y3), ovf_of(q[0].y2),
                                      ovf_of(q[0].y1), ovf_of(q[0].y0)}));
`endif
          void'(q.pop_front());
        end else begin
          chk("out_valid_idle", int'(ov), 0);
        end
        if (rst) begin
          q.delete();
          hist = '{0, 0, 0, 0};
          e0 = -100;
        end else if (in_valid && exp_ready) begin
          hist[3] = hist[2];
          hist[2] = hist[1];
          hist[1] = hist[0];
          hist[0] = int'($signed(xn));
          e.cyc = cyc + 9;
          e.y0 = model_y(0);
          e.y1 = model_y(1);
          e.y2 = model_y(2);
          e.y3 = model_y(3);
          q.push_back(e);
          e0 = cyc + 1;
        end
      end
    end
  end

  // ---------------- driver helpers (called at posedge+1) ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] s);
    int n = 0;
    while (!rdy[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[0]) chk("send_ready_timeout", 0, 1);
    in_valid = 1'b1;
    xn = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    xn = 8'($urandom);
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
  endtask

  typedef struct {
    bit         rst_before;
    logic [7:0] x;
    int         inst;
    int         y;
    bit         ov_flag;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit ok;
    int c1;
    tbl[0]  = '{1'b1, 8'd1,   0, 1,     1'b0};
    tbl[1]  = '{1'b0, 8'd0,   0, 2,     1'b0};
    tbl[2]  = '{1'b0, 8'd0,   0, 3,     1'b0};
    tbl[3]  = '{1'b0, 8'd0,   0, 4,     1'b0};
    tbl[4]  = '{1'b0, 8'd0,   0, 0,     1'b0};
    tbl[5]  = '{1'b1, 8'd127, 1, 127,   1'b0};
    tbl[6]  = '{1'b0, 8'h80,  1, -1,    1'b0};
    tbl[7]  = '{1'b0, 8'd5,   1, 4,     1'b0};
    tbl[8]  = '{1'b0, 8'hFD,  1, 1,     1'b0};
    tbl[9]  = '{1'b1, 8'h80,  2, 16384, 1'b1};
    tbl[10] = '{1'b0, 8'h80,  2, 32768, 1'b1};
    tbl[11] = '{1'b0, 8'h80,  2, 49152, 1'b1};
    tbl[12] = '{1'b0, 8'h80,  2, 65536, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(rdy), 15);
    chk("reset_out_valid", int'(ov), 0);
    chk("reset_fo_a", int'(fo[0]), 0);
    chk("reset_fo_d", int'(fo[3]), 0);
    @(posedge clk); #1;

    // Impulse, mixed signs, extreme range
    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      send(tbl[i].x);
      wait_out(ok);
      if (ok) begin
        chk($sformatf("tbl%0d_y", i), int'($signed(fo[tbl[i].inst])), tbl[i].y);
`ifdef FIR_OVF_FLAG_EN
        chk($sformatf("tbl%0d_ovf", i), int'(ovf[tbl[i].inst]), int'(tbl[i].ov_flag));
`endif
      end
      @(posedge clk); #1;
    end

    // Reset mid-operation at bit plane 4
    do_reset();
    send(8'd10); wait_out(ok); @(posedge clk); #1;
    send(8'd20); wait_out(ok); @(posedge clk); #1;
    send(8'd30); wait_out(ok); @(posedge clk); #1;
    send(8'd50);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(ov), 0);
    chk("midrst_fo_b", int'(fo[1]), 0);
    chk("midrst_in_ready", int'(rdy), 15);
    repeat (12) @(posedge clk);
    #1;
    send(8'd7);
    wait_out(ok);
    if (ok) chk("midrst_y_b", int'($signed(fo[1])), 7);
    @(posedge clk); #1;

    // Back-to-back accept in the out_valid cycle
    do_reset();
    send(8'd11);
    repeat (8) @(posedge clk);
    #1;
    in_valid = 1'b1;
    xn = 8'd22;
    @(negedge clk);
    c1 = cyc;
    chk("b2b_out_valid", int'(ov[1]), 1);
    chk("b2b_in_ready", int'(rdy[1]), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(ok);
    if (ok) begin
      chk("b2b_spacing", cyc - c1, 9);
      chk("b2b_y_b", int'($signed(fo[1])), 33);
    end
    @(posedge clk); #1;

    // Handshake: in_valid held high, xn random every cycle
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      xn = 8'($urandom);
      @(posedge clk); #1;
    end
    // Random valid gaps and random data
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      xn = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
